// File: rtl/sprite_load_arbiter.sv
// Sprite upload sequencer: turns an SPI byte frame into storage writes and
// shares the single storage port with renderer reads, bounding write starvation.
module sprite_load_arbiter #(
    parameter int SPRITE_NUM  = 16,
    parameter int SPRITE_SIZE = 1024,
    parameter int STALL_LIMIT = 8,
    localparam int SEL_W  = $clog2(SPRITE_NUM),
    localparam int ADDR_W = $clog2(SPRITE_SIZE) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              rd_req,
    input  logic [SEL_W-1:0]  rd_sprite,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_grant,
    output logic              rd_data_valid,
    output logic [3:0]        rd_data,
    output logic [SEL_W-1:0]  st_sprite_select,
    output logic              st_w_en,
    output logic [ADDR_W-1:0] st_w_addr,
    output logic [7:0]        st_w_data,
    output logic              st_r_en,
    output logic [ADDR_W-1:0] st_r_addr,
    input  logic [3:0]        st_r_data,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_error
);

    localparam int CNT_W   = ADDR_W - 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(SPRITE_SIZE / 2 - 1);

    typedef enum logic [1:0] {IDLE, HEADER, DATA, DRAIN} state_t;

    state_t              state_q;
    logic                hold_valid_q;
    logic [7:0]          hold_data_q;
    logic [ADDR_W-1:0]   hold_addr_q;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [SEL_W-1:0]    load_sel_q;
    logic                rd_data_valid_q, load_done_q, load_error_q;

    logic force_wr, grant, wr_en, handshake, last_write;

    // A pending write only wins the port once it has lost STALL_LIMIT times.
    assign force_wr   = hold_valid_q && (stall_cnt_q == STALL_MAX);
    assign grant      = rd_req && !force_wr;
    assign wr_en      = hold_valid_q && !grant;
    assign last_write = wr_en && (byte_cnt_q == LAST_BYTE);

    assign rx_ready  = (state_q != DATA) || !hold_valid_q;
    assign handshake = rx_valid && rx_ready;

    assign rd_grant         = grant;
    assign st_r_en          = grant;
    assign st_w_en          = wr_en;
    assign st_sprite_select = grant ? rd_sprite : load_sel_q;
    assign st_r_addr        = rd_addr;
    assign st_w_addr        = hold_addr_q;
    assign st_w_data        = hold_data_q;
    assign rd_data          = st_r_data;
    assign rd_data_valid    = rd_data_valid_q;
    assign load_done        = load_done_q;
    assign load_error       = load_error_q;
    assign load_busy        = (state_q == HEADER) || (state_q == DATA);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        if (wr_en) begin
            stall_cnt_d = '0;
            byte_cnt_d  = byte_cnt_q + 1'b1;
        end else if (hold_valid_q && grant && stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            hold_valid_q    <= 1'b0;
            hold_data_q     <= '0;
            hold_addr_q     <= '0;
            byte_cnt_q      <= '0;
            stall_cnt_q     <= '0;
            load_sel_q      <= '0;
            rd_data_valid_q <= 1'b0;
            load_done_q     <= 1'b0;
            load_error_q    <= 1'b0;
        end else begin
            rd_data_valid_q <= grant;
            load_done_q     <= 1'b0;
            load_error_q    <= 1'b0;
            if (frame_start) begin
                hold_valid_q <= 1'b0;
                byte_cnt_q   <= '0;
                stall_cnt_q  <= '0;
                state_q      <= HEADER;
            end else begin
                stall_cnt_q <= stall_cnt_d;
                byte_cnt_q  <= byte_cnt_d;
                if (wr_en) begin
                    hold_valid_q <= 1'b0;
                end
                if (last_write) begin
                    load_done_q <= 1'b1;
                    byte_cnt_q  <= '0;
                    state_q     <= IDLE;
                end
                case (state_q)
                    HEADER: begin
                        if (handshake) begin
                            if (32'(rx_data) < 32'(SPRITE_NUM)) begin
                                load_sel_q <= rx_data[SEL_W-1:0];
                                byte_cnt_q <= '0;
                                state_q    <= DATA;
                            end else begin
                                load_error_q <= 1'b1;
                                state_q      <= DRAIN;
                            end
                        end
                    end
                    DATA: begin
                        // Byte n of the frame lands on pixel pair 2n, 2n+1.
                        if (handshake) begin
                            hold_data_q  <= rx_data;
                            hold_addr_q  <= {byte_cnt_q, 1'b0};
                            hold_valid_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_load_arbiter.sv
// Randomised bench for sprite_load_arbiter: a storage stub, a frame-level
// reference of expected writes and pixel contents, and scoreboard monitors.
module tb_sprite_load_arbiter;

    localparam int SPRITE_NUM  = 16;
    localparam int SPRITE_SIZE = 1024;
    localparam int STALL_LIMIT = 8;
    localparam int SEL_W       = 4;
    localparam int ADDR_W      = 11;
    localparam int HALF        = SPRITE_SIZE / 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              frame_start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              rd_req;
    logic [SEL_W-1:0]  rd_sprite;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_grant;
    logic              rd_data_valid;
    logic [3:0]        rd_data;
    logic [SEL_W-1:0]  st_sprite_select;
    logic              st_w_en;
    logic [ADDR_W-1:0] st_w_addr;
    logic [7:0]        st_w_data;
    logic              st_r_en;
    logic [ADDR_W-1:0] st_r_addr;
    logic [3:0]        st_r_data;
    logic              load_busy;
    logic              load_done;
    logic              load_error;

    sprite_load_arbiter #(
        .SPRITE_NUM(SPRITE_NUM),
        .SPRITE_SIZE(SPRITE_SIZE),
        .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .frame_start(frame_start),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .rd_req(rd_req),
        .rd_sprite(rd_sprite),
        .rd_addr(rd_addr),
        .rd_grant(rd_grant),
        .rd_data_valid(rd_data_valid),
        .rd_data(rd_data),
        .st_sprite_select(st_sprite_select),
        .st_w_en(st_w_en),
        .st_w_addr(st_w_addr),
        .st_w_data(st_w_data),
        .st_r_en(st_r_en),
        .st_r_addr(st_r_addr),
        .st_r_data(st_r_data),
        .load_busy(load_busy),
        .load_done(load_done),
        .load_error(load_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    int total = 0;
    int bad = 0;

    logic [3:0] stMem  [SPRITE_NUM][SPRITE_SIZE];
    logic [3:0] refMem [SPRITE_NUM][SPRITE_SIZE];
    bit         checkable [SPRITE_NUM];

    wr_t wq[$];
    int  rq[$];
    int  waitCnt = 0;
    bit  expDonePulse = 0;
    int  doneSeen = 0, errSeen = 0, expDone = 0, expErr = 0;
    int  readsChecked = 0;
    bit  rdMode = 0;
    bit  lastGrant = 0;

    int mode = 0;
    int curSel = 0;
    int idx = 0;

    function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endfunction

    // Storage bank stub: byte-wide writes of two pixels, registered 4-bit reads.
    always @(posedge clock) begin
        if (st_w_en) begin
            stMem[st_sprite_select][st_w_addr]     <= st_w_data[7:4];
            stMem[st_sprite_select][st_w_addr + 1] <= st_w_data[3:0];
        end
        if (st_r_en) st_r_data <= stMem[st_sprite_select][st_r_addr];
    end

    // Frame-level reference: what each handshaken byte should mean.
    function automatic void modelByte(input logic [7:0] b);
        case (mode)
            1: begin
                if (int'(b) < SPRITE_NUM) begin
                    curSel = int'(b);
                    idx = 0;
                    mode = 2;
                    checkable[curSel] = 0;
                end else begin
                    expErr++;
                    mode = 3;
                end
            end
            2: begin
                wq.push_back('{sel: SEL_W'(curSel), addr: ADDR_W'(2 * idx), data: b});
                refMem[curSel][2 * idx]     = b[7:4];
                refMem[curSel][2 * idx + 1] = b[3:0];
                idx++;
                if (idx == HALF) begin
                    mode = 0;
                    expDone++;
                end
            end
            default: ;
        endcase
    endfunction

    // Monitor: scoreboards for writes and read data plus per-cycle port rules.
    always @(negedge clock) begin
        wr_t w;
        int e;
        if (reset) begin
            checkOutput("reset_w_en", 32'(st_w_en), 0);
            checkOutput("reset_rd_grant", 32'(rd_grant), 32'(rd_req));
            checkOutput("reset_r_en", 32'(st_r_en), 32'(rd_req));
            checkOutput("reset_rd_valid", 32'(rd_data_valid), 0);
            checkOutput("reset_busy", 32'(load_busy), 0);
        end else begin
            checkOutput("enable_excl", 32'(st_w_en & st_r_en), 0);
            if (rd_req && !st_w_en) checkOutput("grant_given", 32'(rd_grant), 1);
            if (!rd_req) checkOutput("grant_no_req", 32'(rd_grant), 0);
            if (rd_grant) checkOutput("rd_port", 32'({st_sprite_select, st_r_addr}), 32'({rd_sprite, rd_addr}));
            if (wq.size() > 0) checkOutput("rx_ready_hold", 32'(rx_ready), 0);
            checkOutput("load_done", 32'(load_done), 32'(expDonePulse));
            expDonePulse = 0;
            if (load_done) doneSeen++;
            if (load_error) errSeen++;

            if (rd_data_valid) begin
                if (rq.size() == 0) checkOutput("rd_unexpected", 1, 0);
                else begin
                    e = rq.pop_front();
                    if (e >= 0) begin
                        checkOutput("rd_data", 32'(rd_data), 32'(e));
                        readsChecked++;
                    end
                end
            end
            if (rd_grant) rq.push_back(checkable[rd_sprite] ? int'(refMem[rd_sprite][rd_addr]) : -1);

            if (wq.size() > 0 && rd_grant) waitCnt++;
            if (st_w_en) begin
                if (wq.size() == 0) checkOutput("write_unexpected", 1, 0);
                else begin
                    w = wq.pop_front();
                    checkOutput("write", 32'({st_sprite_select, st_w_addr, st_w_data}), 32'(w));
                    if (rd_req) checkOutput("stall_wait", 32'(waitCnt), STALL_LIMIT);
                    else if (waitCnt > STALL_LIMIT) checkOutput("stall_bound", 32'(waitCnt), STALL_LIMIT);
                    if (int'(w.addr) == SPRITE_SIZE - 2) expDonePulse = 1;
                end
                waitCnt = 0;
            end
            lastGrant = rd_grant;
        end
    end

    // Background renderer: holds each request until granted, then moves on.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rdMode && (!rd_req || lastGrant)) begin
                rd_req    = 1'b1;
                rd_sprite = SEL_W'($urandom_range(0, SPRITE_NUM - 1));
                rd_addr   = ADDR_W'($urandom_range(0, SPRITE_SIZE - 1));
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        bit acc = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!acc && n < 100) begin
            @(negedge clock);
            if (rx_ready) acc = 1;
            @(posedge clock);
            #1;
            n++;
        end
        if (!acc) checkOutput("rx_timeout", 0, 1);
        else modelByte(b);
    endtask

    task automatic frameStart();
        rx_valid    = 1'b0;
        frame_start = 1'b1;
        @(posedge clock);
        #1;
        frame_start = 1'b0;
        mode = 1;
    endtask

    task automatic waitDrain();
        int n = 0;
        rx_valid = 1'b0;
        while (wq.size() > 0 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (wq.size() > 0) checkOutput("drain_timeout", 32'(wq.size()), 0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic loadSprite(input int sel, input int nBytes, input bit fixed, input logic [7:0] fixedVal);
        frameStart();
        applyStimulus(8'(sel));
        for (int i = 0; i < nBytes; i++) applyStimulus(fixed ? fixedVal : 8'($urandom));
        waitDrain();
        if (nBytes == HALF) checkable[sel] = 1;
    endtask

    task automatic readPixel(input int s, input int a);
        int n = 0;
        rd_req    = 1'b1;
        rd_sprite = SEL_W'(s);
        rd_addr   = ADDR_W'(a);
        do begin
            @(negedge clock);
            n++;
        end while (!rd_grant && n < 50);
        if (!rd_grant) checkOutput("read_timeout", 0, 1);
        @(posedge clock);
        #1;
        rd_req = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < SPRITE_NUM; s++) begin
            checkable[s] = 1;
            for (int a = 0; a < SPRITE_SIZE; a++) begin
                refMem[s][a] = 4'($urandom);
                stMem[s][a]  = refMem[s][a];
            end
        end
        reset = 1'b1;
        frame_start = 1'b0;
        rx_valid = 1'b0;
        rx_data = '0;
        rd_req = 1'b1;
        rd_sprite = '0;
        rd_addr = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        rd_req = 1'b0;
        @(posedge clock);
        #1;

        // Full sprite 5 of 0xA5 with no reads, then read back the first pair.
        frameStart();
        @(negedge clock);
        checkOutput("busy_header", 32'(load_busy), 1);
        @(posedge clock);
        #1;
        applyStimulus(8'h05);
        for (int i = 0; i < HALF; i++) applyStimulus(8'hA5);
        waitDrain();
        checkable[5] = 1;
        checkOutput("busy_after_done", 32'(load_busy), 0);
        checkOutput("done_count_5", 32'(doneSeen), 1);
        readPixel(5, 0);
        readPixel(5, 1);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("readback_count", 32'(readsChecked), 2);

        // Out-of-range header: error pulse, then bytes drained without writes.
        frameStart();
        applyStimulus(8'h10);
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom));
        waitDrain();
        checkOutput("load_error_count", 32'(errSeen), 1);
        checkOutput("busy_drain", 32'(load_busy), 0);

        // Continuous renderer traffic during a full load of sprite 9.
        rdMode = 1;
        loadSprite(9, HALF, 0, 8'h00);
        rdMode = 0;
        rd_req = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // Abandon sprite 2 after 100 bytes and load sprite 7 instead.
        loadSprite(2, 100, 0, 8'h00);
        loadSprite(7, HALF, 0, 8'h00);

        // Asynchronous reset with sprite 3 part-loaded, then a clean reload.
        frameStart();
        applyStimulus(8'h03);
        for (int i = 0; i < 10; i++) applyStimulus(8'($urandom));
        reset = 1'b1;
        wq.delete();
        rq.delete();
        waitCnt = 0;
        expDonePulse = 0;
        mode = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post_reset_busy", 32'(load_busy), 0);
        checkOutput("post_reset_w_en", 32'(st_w_en), 0);
        @(posedge clock);
        #1;
        loadSprite(3, HALF, 0, 8'h00);

        for (int i = 0; i < 16; i++) readPixel($urandom_range(0, SPRITE_NUM - 1), $urandom_range(0, SPRITE_SIZE - 1));
        repeat (4) @(posedge clock);
        #1;
        checkOutput("done_total", 32'(doneSeen), 32'(expDone));
        checkOutput("error_total", 32'(errSeen), 32'(expErr));
        checkOutput("write_queue_empty", 32'(wq.size()), 0);
        checkOutput("read_queue_empty", 32'(rq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
